// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI channel-voice message parser.
// Optional build macro used by the parser: MIDI_CHAN_FILTER_EN.
package midi_pkg;

  // Parser states: no running status, awaiting first/second data byte,
  // or discarding the payload of a SysEx / system-common message.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SKIP    = 2'd3
  } state_e;

  // Message type codes are status bits [6:4].
  localparam logic [2:0] MT_NOTE_OFF   = 3'd0;
  localparam logic [2:0] MT_NOTE_ON    = 3'd1;
  localparam logic [2:0] MT_POLY_AT    = 3'd2;
  localparam logic [2:0] MT_CC         = 3'd3;
  localparam logic [2:0] MT_PROG_CHG   = 3'd4;
  localparam logic [2:0] MT_CHAN_AT    = 3'd5;
  localparam logic [2:0] MT_PITCH_BEND = 3'd6;

  // Byte-class boundaries.
  localparam logic [7:0] RT_MIN  = 8'hF8;  // 0xF8..0xFF: real-time
  localparam logic [7:0] SYS_MIN = 8'hF0;  // 0xF0..0xF7: SysEx / system common
  localparam logic [7:0] SYS_EOX = 8'hF7;  // end of exclusive

  // Number of data bytes carried by a channel message, from the status
  // byte's high nibble: program change and channel aftertouch carry one.
  function automatic logic [1:0] data_len(input logic [3:0] status_hi);
    if (status_hi == 4'hC || status_hi == 4'hD) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage : midi_pkg

// File: rtl/midi_status_decode.sv
// Combinational classifier for one received MIDI byte.
module midi_status_decode
  import midi_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_status_o,  // channel status 0x80..0xEF
  output logic       is_rt_o,      // real-time 0xF8..0xFF
  output logic       is_sys_o,     // SysEx / system common 0xF0..0xF7
  output logic       is_eox_o,     // 0xF7 end of exclusive
  output logic       needs_two_o   // channel message carries two data bytes
);

  // Pure byte-class decode; data bytes are the case where none of the
  // three class flags is set.
  always_comb begin
    is_rt_o     = (byte_i >= RT_MIN);
    is_sys_o    = (byte_i >= SYS_MIN) && (byte_i < RT_MIN);
    is_eox_o    = (byte_i == SYS_EOX);
    is_status_o = byte_i[7] && (byte_i < SYS_MIN);
    needs_two_o = (data_len(byte_i[7:4]) == 2'd2);
  end

endmodule : midi_status_decode

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message parser: assembles status/data bytes from the
// UART receiver into complete messages with running status, transparent
// real-time bytes and SysEx/system-common skipping.
// Optional build macro: MIDI_CHAN_FILTER_EN -- report only messages on
// LISTEN_CHANNEL (parsing and running status still track all channels).
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter  int NUM_CHANNELS   = 16,
  parameter  int LISTEN_CHANNEL = 0,
  localparam int CHAN_W         = $clog2(NUM_CHANNELS)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              byte_valid_in,
  input  logic [7:0]        byte_in,
  output logic              msg_valid_out,
  output logic [2:0]        msg_type_out,
  output logic [CHAN_W-1:0] chan_out,
  output logic [6:0]        data1_out,
  output logic [6:0]        data2_out,
  output logic              err_out
);

  localparam logic [CHAN_W-1:0] LISTEN_CHAN = CHAN_W'(LISTEN_CHANNEL);

  // Byte classification.
  logic is_status, is_rt, is_sys, is_eox, needs_two;

  midi_status_decode u_decode (
    .byte_i      (byte_in),
    .is_status_o (is_status),
    .is_rt_o     (is_rt),
    .is_sys_o    (is_sys),
    .is_eox_o    (is_eox),
    .needs_two_o (needs_two)
  );

  // Parser state and running status.
  state_e            state_q, state_d;
  logic [2:0]        rs_type_q, rs_type_d;   // running status type
  logic [CHAN_W-1:0] rs_chan_q, rs_chan_d;   // running status channel
  logic              rs_two_q, rs_two_d;     // running status needs data2
  logic [6:0]        d1_hold_q, d1_hold_d;   // data1 awaiting data2

  // Registered message/error outputs.
  logic              msg_valid_q, err_q;
  logic [2:0]        msg_type_q;
  logic [CHAN_W-1:0] chan_q;
  logic [6:0]        data1_q, data2_q;

  // Combinational completion results.
  logic       complete;
  logic       err_d;
  logic [6:0] cmp_d1, cmp_d2;
  logic [2:0] cmp_type;
  logic       chan_match;
  logic       report;

`ifdef MIDI_CHAN_FILTER_EN
  assign chan_match = (rs_chan_q == LISTEN_CHAN);
`else
  logic unused_listen;
  assign chan_match    = 1'b1;
  assign unused_listen = ^LISTEN_CHAN;
`endif

  // Next-state / running-status / completion decode for the current byte.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned -- that is what keeps this block free of inferred latches.
  always_comb begin
    state_d   = state_q;
    rs_type_d = rs_type_q;
    rs_chan_d = rs_chan_q;
    rs_two_d  = rs_two_q;
    d1_hold_d = d1_hold_q;
    complete  = 1'b0;
    err_d     = 1'b0;
    cmp_d1    = 7'd0;
    cmp_d2    = 7'd0;

    if (byte_valid_in && !is_rt) begin
      if (is_sys) begin
        // Any system byte cancels running status without error. EOX closes
        // a SysEx, so later stray data is again an error from IDLE.
        rs_type_d = 3'd0;
        rs_chan_d = '0;
        rs_two_d  = 1'b0;
        state_d   = is_eox ? ST_IDLE : ST_SKIP;
      end else if (is_status) begin
        // A new channel status abandons a half-received message only in
        // WAIT_D2: WAIT_D1 never holds a data byte of the current message,
        // since a data byte there either completes or moves to WAIT_D2.
        err_d     = (state_q == ST_WAIT_D2);
        rs_type_d = byte_in[6:4];
        rs_chan_d = byte_in[CHAN_W-1:0];
        rs_two_d  = needs_two;
        state_d   = ST_WAIT_D1;
      end else begin
        unique case (state_q)
          ST_IDLE: err_d = 1'b1;
          ST_SKIP: ;
          ST_WAIT_D1: begin
            if (rs_two_q) begin
              d1_hold_d = byte_in[6:0];
              state_d   = ST_WAIT_D2;
            end else begin
              complete = 1'b1;
              cmp_d1   = byte_in[6:0];
            end
          end
          ST_WAIT_D2: begin
            complete = 1'b1;
            cmp_d1   = d1_hold_q;
            cmp_d2   = byte_in[6:0];
            state_d  = ST_WAIT_D1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // NoteOn with zero velocity is reported as NoteOff.
    cmp_type = rs_type_q;
    if (rs_type_q == MT_NOTE_ON && cmp_d2 == 7'd0) begin
      cmp_type = MT_NOTE_OFF;
    end
  end

  assign report = complete && chan_match;

  // Parser state and running-status registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      rs_type_q <= 3'd0;
      rs_chan_q <= '0;
      rs_two_q  <= 1'b0;
      d1_hold_q <= 7'd0;
    end else begin
      state_q   <= state_d;
      rs_type_q <= rs_type_d;
      rs_chan_q <= rs_chan_d;
      rs_two_q  <= rs_two_d;
      d1_hold_q <= d1_hold_d;
    end
  end

  // Output registers: strobes for one cycle, message fields hold until the
  // next reported completion.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      msg_valid_q <= 1'b0;
      err_q       <= 1'b0;
      msg_type_q  <= 3'd0;
      chan_q      <= '0;
      data1_q     <= 7'd0;
      data2_q     <= 7'd0;
    end else begin
      msg_valid_q <= report;
      err_q       <= err_d;
      if (report) begin
        msg_type_q <= cmp_type;
        chan_q     <= rs_chan_q;
        data1_q    <= cmp_d1;
        data2_q    <= cmp_d2;
      end
    end
  end

  assign msg_valid_out = msg_valid_q;
  assign err_out       = err_q;
  assign msg_type_out  = msg_type_q;
  assign chan_out      = chan_q;
  assign data1_out     = data1_q;
  assign data2_out     = data2_q;

endmodule : midi_msg_parser
